hdl_1: RTL and testbench

Four-input single-output Boolean function block implementing F(A,B,C,D) = Σm(0,1,8,9,10,11,12,14,15), A as MSB. Its combinational output F serves glue-logic consumers. A registered copy and usage statistics serve the synchronous datapath. A built-in cross-check compares the minimized SOP against a minterm lookup and flags disagreement for bring-up diagnostics.

---
 rtl/hdl_1_pkg.sv | 16 +
 rtl/hdl_1_sop.sv | 19 +
 rtl/hdl_1.sv | 72 +++++++
 tb/tb_hdl_1.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hdl_1_pkg.sv
// ---------------------------------------------------------------------------
// hdl_1_pkg
// Shared constants and types for the hdl_1 Boolean function block.
//   MINTERM_MASK : bit i set when F(idx=i) = 1, idx = {A,B,C,D}
//   CNT_W/CNT_MAX: width and saturation value of the ones counter
//   idx_t        : 4-bit truth-table index type
// ---------------------------------------------------------------------------
package hdl_1_pkg;

  localparam logic [15:0] MINTERM_MASK = 16'hDF03;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef logic [3:0] idx_t;

endpackage

// File: rtl/hdl_1_sop.sv
// ---------------------------------------------------------------------------
// hdl_1_sop
// Minimized sum-of-products form of F(A,B,C,D) = sum m(0,1,8,9,10,11,12,14,15).
// Ports:
//   A,B,C,D : function inputs, A is the MSB
//   F       : combinational result, F = B'C' + AD' + AC
// ---------------------------------------------------------------------------
module hdl_1_sop (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic F
);

  // Three prime implicants cover every required minterm with no extra ones.
  assign F = (~B & ~C) | (A & ~D) | (A & C);

endmodule

// File: rtl/hdl_1.sv
// ---------------------------------------------------------------------------
// hdl_1
// Four-input Boolean function block with a registered copy of the result,
// a saturating count of enabled samples where F=1, and a sticky flag raised
// when the SOP logic disagrees with the minterm lookup.
// Ports:
//   clk      : system clock, state updates on rising edge
//   rst_n    : asynchronous active-low reset
//   A,B,C,D  : function inputs, A is the MSB
//   en       : sample enable for all registered state
//   F        : combinational function result (independent of clk/rst_n/en)
//   F_q      : F captured on enabled edges
//   ones_cnt : saturating count of enabled samples with F=1
//   mismatch : sticky SOP-vs-lookup disagreement flag, cleared only by reset
// ---------------------------------------------------------------------------
module hdl_1
  import hdl_1_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  input  logic             en,
  output logic             F,
  output logic             F_q,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             mismatch
);

  idx_t             w_idx;
  logic             w_f;
  logic             w_fLut;
  logic             r_fQ;
  logic [CNT_W-1:0] r_onesCnt;
  logic             r_mismatch;

  hdl_1_sop uSop (
    .A (A),
    .B (B),
    .C (C),
    .D (D),
    .F (w_f)
  );

  // The lookup is an independent reference implementation used only to
  // cross-check the minimized logic during bring-up.
  assign w_idx  = {A, B, C, D};
  assign w_fLut = MINTERM_MASK[w_idx];

  // Registered path: everything holds unless en is high; reset wins over en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fQ       <= 1'b0;
      r_onesCnt  <= '0;
      r_mismatch <= 1'b0;
    end else if (en) begin
      r_fQ <= w_f;
      if (w_f && (r_onesCnt != CNT_MAX)) begin
        r_onesCnt <= r_onesCnt + CNT_W'(1);
      end
      r_mismatch <= r_mismatch | (w_f ^ w_fLut);
    end
  end

  assign F        = w_f;
  assign F_q      = r_fQ;
  assign ones_cnt = r_onesCnt;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_hdl_1.sv
// ---------------------------------------------------------------------------
// tb_hdl_1
// Directed self-checking bench for hdl_1.
// ---------------------------------------------------------------------------
module tb_hdl_1;

  logic       clk;
  logic       rst_n;
  logic       A, B, C, D;
  logic       en;
  logic       F;
  logic       F_q;
  logic [7:0] ones_cnt;
  logic       mismatch;

  int checks   = 0;
  int failures = 0;
  int expCnt   = 0;

  // Hand-written truth table for idx 0..15.
  logic expF [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  hdl_1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .en       (en),
    .F        (F),
    .F_q      (F_q),
    .ones_cnt (ones_cnt),
    .mismatch (mismatch)
  );

  // 10 ns clock; inputs change and outputs are sampled around the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the function index and the enable.
  task automatic applyStimulus(input int idx, input logic enVal);
    logic [3:0] v;
    v  = idx[3:0];
    A  = v[3];
    B  = v[2];
    C  = v[1];
    D  = v[0];
    en = enVal;
  endtask

  // One comparison: counts it, and on disagreement counts a failure and reports.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state: registers cleared, F still combinational.
    rst_n = 1'b0;
    applyStimulus(0, 1'b0);
    #12;
    checkOutput("reset_F_q", {7'd0, F_q}, 8'd0);
    checkOutput("reset_ones_cnt", ones_cnt, 8'd0);
    checkOutput("reset_mismatch", {7'd0, mismatch}, 8'd0);
    checkOutput("reset_F", {7'd0, F}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep with en=0: F follows the table, registers hold.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(i, 1'b0);
      #1;
      checkOutput($sformatf("sweep_F_idx%0d", i), {7'd0, F}, {7'd0, expF[i]});
    end
    @(negedge clk);
    checkOutput("sweep_F_q_held", {7'd0, F_q}, 8'd0);
    checkOutput("sweep_cnt_held", ones_cnt, 8'd0);

    // Asynchronous reset mid-operation after five enabled samples of idx 0.
    applyStimulus(0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("pre_rst_cnt", ones_cnt, 8'd5);
    checkOutput("pre_rst_F_q", {7'd0, F_q}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_F_q", {7'd0, F_q}, 8'd0);
    checkOutput("async_rst_cnt", ones_cnt, 8'd0);
    checkOutput("async_rst_mismatch", {7'd0, mismatch}, 8'd0);
    checkOutput("async_rst_F", {7'd0, F}, 8'd1);
    en = 1'b0;
    @(negedge clk);
    checkOutput("rst_holds_cnt", ones_cnt, 8'd0);
    rst_n = 1'b1;

    // Registered path: one enabled sample per cycle, idx 0..15.
    expCnt = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, 1'b1);
      @(negedge clk);
      if (expF[i]) expCnt++;
      checkOutput($sformatf("reg_F_q_idx%0d", i), {7'd0, F_q}, {7'd0, expF[i]});
      checkOutput($sformatf("reg_cnt_idx%0d", i), ones_cnt, 8'(expCnt));
    end
    checkOutput("reg_cnt_total", ones_cnt, 8'd9);
    checkOutput("reg_mismatch", {7'd0, mismatch}, 8'd0);

    // One enabled sample at idx 13 (F=0): F_q drops, count unchanged.
    applyStimulus(13, 1'b1);
    @(negedge clk);
    checkOutput("idx13_F_q", {7'd0, F_q}, 8'd0);
    checkOutput("idx13_cnt", ones_cnt, 8'd9);

    // Enable gating: idx 15 (F=1) for 10 cycles with en=0.
    applyStimulus(15, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("gate_cnt", ones_cnt, 8'd9);
    checkOutput("gate_F_q", {7'd0, F_q}, 8'd0);
    checkOutput("gate_F", {7'd0, F}, 8'd1);

    // Saturation: idx 12 (F=1) enabled for 300 cycles, starting from 9.
    applyStimulus(12, 1'b1);
    repeat (245) @(negedge clk);
    checkOutput("sat_cnt_254", ones_cnt, 8'd254);
    @(negedge clk);
    checkOutput("sat_cnt_255", ones_cnt, 8'd255);
    repeat (54) @(negedge clk);
    checkOutput("sat_cnt_hold", ones_cnt, 8'd255);
    checkOutput("sat_F_q", {7'd0, F_q}, 8'd1);
    checkOutput("sat_mismatch", {7'd0, mismatch}, 8'd0);

    // Boundary minterms.
    applyStimulus(13, 1'b0);
    #1 checkOutput("bound_idx13", {7'd0, F}, 8'd0);
    applyStimulus(2, 1'b0);
    #1 checkOutput("bound_idx2", {7'd0, F}, 8'd0);
    applyStimulus(12, 1'b0);
    #1 checkOutput("bound_idx12", {7'd0, F}, 8'd1);
    applyStimulus(1, 1'b0);
    #1 checkOutput("bound_idx1", {7'd0, F}, 8'd1);

    // Reset asserted while en=1 clears the saturated counter.
    applyStimulus(12, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("final_rst_cnt", ones_cnt, 8'd0);
    checkOutput("final_rst_F_q", {7'd0, F_q}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
